// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: tick-driven digit scan with an
// anode guard interval, frame-boundary value commit and leading-zero blanking.
module seg7_scan #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned GUARD          = 4,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input  logic                  inclk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic                  ack,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned GCNT_W = 4;
    localparam int unsigned VAL_W  = 4 * DIGITS;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [GCNT_W-1:0] GUARD_LD = GCNT_W'(GUARD);
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;

    logic [IDX_W-1:0]  r_idx;
    logic [VAL_W-1:0]  r_disp;
    logic [DIGITS-1:0] r_disp_dp;
    logic [VAL_W-1:0]  r_pend_val;
    logic [DIGITS-1:0] r_pend_dp;
    logic              r_pend;
    logic [GCNT_W-1:0] r_gcnt;
    logic              r_run;
    logic              r_ack;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_dp;

    logic              w_wrap;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [3:0]        w_nib;
    logic              w_dp_sel;
    logic              w_acc;
    logic [DIGITS-1:0] w_zero_from;
    logic              w_blank;
    logic [DIGITS-1:0] w_onehot;
    logic [DIGITS-1:0] w_an_on;
    logic [6:0]        w_seg_nxt;
    logic              w_dp_nxt;

    // Active-high hex to segment pattern, bit0 = a .. bit6 = g.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_wrap    = (r_idx == LAST_IDX);
    assign w_idx_nxt = w_wrap ? '0 : r_idx + IDX_W'(1);
    assign w_onehot  = DIGITS'(1) << r_idx;
    assign w_an_on   = AN_ACTIVE_LOW ? ~w_onehot : w_onehot;

    // Select the current digit and find where the run of leading zeros starts.
    always_comb begin
        w_nib       = '0;
        w_dp_sel    = 1'b0;
        w_acc       = 1'b1;
        w_zero_from = '0;
        w_blank     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_acc          = w_acc & (r_disp[4*i +: 4] == 4'h0);
            w_zero_from[i] = w_acc;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib    = r_disp[4*i +: 4];
                w_dp_sel = r_disp_dp[i];
                w_blank  = BLANK_LEADING && (i > 0) && w_zero_from[i];
            end
        end
    end

    always_comb begin
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = DP_OFF;
        if (!w_blank) begin
            w_seg_nxt = SEG_ACTIVE_LOW ? ~hex7(w_nib) : hex7(w_nib);
        end
        w_dp_nxt = SEG_ACTIVE_LOW ? ~w_dp_sel : w_dp_sel;
    end

    // Outputs stay at their off level until the first tick after reset.
    always_ff @(posedge inclk) begin
        if (rst) begin
            r_idx      <= '0;
            r_disp     <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend     <= 1'b0;
            r_gcnt     <= '0;
            r_run      <= 1'b0;
            r_ack      <= 1'b0;
            r_an       <= AN_OFF;
            r_seg      <= SEG_OFF;
            r_dp       <= DP_OFF;
        end else begin
            r_ack <= load;
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
            end
            // Old pending value commits even when a new one is captured this edge.
            if (tick && w_wrap && r_pend) begin
                r_disp    <= r_pend_val;
                r_disp_dp <= r_pend_dp;
            end
            if (load) begin
                r_pend <= 1'b1;
            end else if (tick && w_wrap) begin
                r_pend <= 1'b0;
            end
            if (tick) begin
                r_idx  <= w_idx_nxt;
                r_gcnt <= GUARD_LD;
                r_an   <= AN_OFF;
                r_run  <= 1'b1;
            end else if (r_gcnt != '0) begin
                r_gcnt <= r_gcnt - GCNT_W'(1);
                if (r_gcnt == GCNT_W'(1)) begin
                    r_an <= w_an_on;
                end
            end
            if (r_run) begin
                r_seg <= w_seg_nxt;
                r_dp  <= w_dp_nxt;
            end
        end
    end

    assign ack = r_ack;
    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a table of display values checked over full
// scan frames, plus hand sequences for tearing, load-on-wrap and reset/guard cases.
module tb_seg7_scan;

    logic        inclk = 1'b0;
    logic        rst   = 1'b1;
    logic        tick  = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load  = 1'b0;
    logic        ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_err = 0;

    seg7_scan #(
        .DIGITS(4), .GUARD(4), .AN_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut (
        .inclk(inclk), .rst(rst), .tick(tick), .value(value), .dp_in(dp_in),
        .load(load), .ack(ack), .an(an), .seg(seg), .dp(dp)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic [6:0]  segs [4];
        logic [3:0]  dpo;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpi, input string nm);
        value = v;
        dp_in = dpi;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk({nm, "_ack1"}, 16'(ack), 16'h1);
        step();
        chk({nm, "_ack0"}, 16'(ack), 16'h0);
    endtask

    // Tick, then check blanked anodes, the new digit's segments and the guard length.
    task automatic tick_chk(input int d, input logic [6:0] es, input logic edp, input string nm);
        logic [3:0] an_exp;
        an_exp = ~(4'b0001 << d);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk({nm, "_an_off"}, 16'(an), 16'hF);
        step();
        chk({nm, "_seg"}, 16'(seg), 16'(es));
        chk({nm, "_dp"}, 16'(dp), 16'(edp));
        step();
        step();
        chk({nm, "_an_guard"}, 16'(an), 16'hF);
        step();
        chk({nm, "_an_on"}, 16'(an), 16'(an_exp));
        repeat (6) step();
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, '{7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111};
        tbl[1] = '{16'h0007, 4'b0000, '{7'h78, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
        tbl[2] = '{16'h0000, 4'b0000, '{7'h40, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
        tbl[3] = '{16'hABCD, 4'b0101, '{7'h21, 7'h46, 7'h03, 7'h08}, 4'b1010};
        tbl[4] = '{16'h0500, 4'b1000, '{7'h40, 7'h40, 7'h12, 7'h7F}, 4'b0111};
        tbl[5] = '{16'hEF98, 4'b0000, '{7'h00, 7'h10, 7'h0E, 7'h06}, 4'b1111};
        tbl[6] = '{16'h0010, 4'b0001, '{7'h40, 7'h79, 7'h7F, 7'h7F}, 4'b1110};

        // Reset values after a long idle period.
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_ack", 16'(ack), 16'h0);

        // Walk to idx 3 while showing the all-zero reset value.
        for (int d = 1; d < 4; d++) tick_chk(d, 7'h7F, 1'b1, $sformatf("pro_d%0d", d));

        // Each vector is loaded at idx 3, commits on the wrap, then scans a full frame.
        for (int i = 0; i < 7; i++) begin
            do_load(tbl[i].val, tbl[i].dpi, $sformatf("v%0d_ld", i));
            for (int d = 0; d < 4; d++)
                tick_chk(d, tbl[i].segs[d], tbl[i].dpo[d], $sformatf("v%0d_d%0d", i, d));
        end

        // No tearing: value 0010 stays up until the wrap; 5555 replaces ABCD.
        tick_chk(0, 7'h40, 1'b0, "nt_d0");
        do_load(16'hABCD, 4'b0000, "nt_ld1");
        tick_chk(1, 7'h79, 1'b1, "nt_d1");
        tick_chk(2, 7'h7F, 1'b1, "nt_d2");
        do_load(16'h5555, 4'b0000, "nt_ld2");
        tick_chk(3, 7'h7F, 1'b1, "nt_d3");
        for (int d = 0; d < 4; d++) tick_chk(d, 7'h12, 1'b1, $sformatf("nt_new_d%0d", d));

        // Load 9 on the same edge as the wrap with 8 already pending.
        do_load(16'h0008, 4'b0000, "lw_ld8");
        value = 16'h0009;
        load  = 1'b1;
        tick  = 1'b1;
        step();
        load  = 1'b0;
        tick  = 1'b0;
        chk("lw_ack", 16'(ack), 16'h1);
        chk("lw_an_off", 16'(an), 16'hF);
        step();
        chk("lw_seg8", 16'(seg), 16'h00);
        repeat (3) step();
        chk("lw_an_on", 16'(an), 16'hE);
        repeat (6) step();
        for (int d = 1; d < 4; d++) tick_chk(d, 7'h7F, 1'b1, $sformatf("lw_d%0d", d));
        tick_chk(0, 7'h10, 1'b1, "lw_seg9");

        // Reset two cycles after a tick, with load and tick asserted alongside.
        do_load(16'h0003, 4'b0000, "rg_ld");
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        rst   = 1'b1;
        load  = 1'b1;
        tick  = 1'b1;
        value = 16'h0006;
        step();
        rst  = 1'b0;
        load = 1'b0;
        tick = 1'b0;
        chk("rg_an", 16'(an), 16'hF);
        chk("rg_seg", 16'(seg), 16'h7F);
        chk("rg_dp", 16'(dp), 16'h1);
        chk("rg_ack", 16'(ack), 16'h0);
        repeat (8) step();
        chk("rg_an_idle", 16'(an), 16'hF);
        chk("rg_seg_idle", 16'(seg), 16'h7F);
        for (int d = 1; d < 4; d++) tick_chk(d, 7'h7F, 1'b1, $sformatf("rg_d%0d", d));
        tick_chk(0, 7'h40, 1'b1, "rg_nopend");

        // Second tick inside the guard window restarts it; only digit 2 lights.
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        chk("tg_an_n1", 16'(an), 16'hF);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("tg_an_m0", 16'(an), 16'hF);
        step();
        chk("tg_seg", 16'(seg), 16'h7F);
        step();
        step();
        chk("tg_an_m3", 16'(an), 16'hF);
        step();
        chk("tg_an_m4", 16'(an), 16'hB);
        repeat (5) step();
        chk("tg_an_hold", 16'(an), 16'hB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
